// File: rtl/score_update_module.sv
// Line-clear score accumulator: weights each event by the current level through
// repeated addition, and tracks cleared lines, level and dropped-event errors.
module score_update_module (
    input  logic       clk,
    input  logic       rst,
    input  logic       game_restart,
    input  logic       clr_valid,
    input  logic [2:0] clr_lines,
    output logic       clr_ready,
    output logic [7:0] cur_score_bin,
    output logic [3:0] level,
    output logic [7:0] total_lines,
    output logic       score_upd,
    output logic       drop_err
);

    typedef enum logic [1:0] {IDLE, ADD, LINES} state_t;

    state_t     state;
    logic [3:0] base;
    logic [2:0] n;
    logic [3:0] iter;
    logic [3:0] lvl_cnt;

    logic [3:0] base_lut;
    logic       lines_ok;
    logic [8:0] score_sum;
    logic [8:0] lines_sum;
    logic [4:0] lvl_sum;

    assign clr_ready = (state == IDLE);
    assign lines_ok  = (clr_lines >= 3'd1) && (clr_lines <= 3'd4);

    always_comb begin
        base_lut = 4'd0;
        case (clr_lines)
            3'd1:    base_lut = 4'd1;
            3'd2:    base_lut = 4'd3;
            3'd3:    base_lut = 4'd5;
            3'd4:    base_lut = 4'd8;
            default: base_lut = 4'd0;
        endcase
    end

    // Wide sums so overflow is visible for clamping.
    assign score_sum = {1'b0, cur_score_bin} + {5'd0, base};
    assign lines_sum = {1'b0, total_lines} + {6'd0, n};
    assign lvl_sum   = {1'b0, lvl_cnt} + {2'd0, n};

    always_ff @(posedge clk) begin
        if (rst || game_restart) begin
            state         <= IDLE;
            base          <= 4'd0;
            n             <= 3'd0;
            iter          <= 4'd0;
            lvl_cnt       <= 4'd0;
            cur_score_bin <= 8'd0;
            level         <= 4'd1;
            total_lines   <= 8'd0;
            score_upd     <= 1'b0;
            drop_err      <= 1'b0;
        end else begin
            score_upd <= 1'b0;
            if (clr_valid && state != IDLE)
                drop_err <= 1'b1;
            case (state)
                IDLE: begin
                    if (clr_valid && lines_ok) begin
                        base  <= base_lut;
                        n     <= clr_lines;
                        iter  <= level;
                        state <= ADD;
                    end
                end
                ADD: begin
                    cur_score_bin <= score_sum[8] ? 8'd255 : score_sum[7:0];
                    iter          <= iter - 4'd1;
                    if (iter == 4'd1)
                        state <= LINES;
                end
                LINES: begin
                    total_lines <= lines_sum[8] ? 8'd255 : lines_sum[7:0];
                    if (lvl_sum >= 5'd10) begin
                        lvl_cnt <= 4'(lvl_sum - 5'd10);
                        if (level < 4'd9)
                            level <= level + 4'd1;
                    end else begin
                        lvl_cnt <= lvl_sum[3:0];
                    end
                    score_upd <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
